// File: rtl/id_ex_if.sv
// ID/EX stage bus: decoded ID fields in, registered EX fields and hazard status out.
// Valid/ready note: id_valid qualifies the ID slot; stall_in is the only back-pressure and freezes EX.
interface id_ex_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_regdst, id_memtoreg, id_alusrc, id_regwrite;
    logic [1:0]       id_jump, id_branch, id_memread, id_memwrite, id_aluop;
    logic [31:0]      id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]       id_rs, id_rt, id_rd;
    logic [5:0]       id_funct;
    logic             flush;
    logic             stall_in;

    logic             ex_valid;
    logic             ex_regdst, ex_memtoreg, ex_alusrc, ex_regwrite;
    logic [1:0]       ex_jump, ex_branch, ex_memread, ex_memwrite, ex_aluop;
    logic [31:0]      ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]       ex_rs, ex_rt, ex_rd;
    logic [5:0]       ex_funct;
    logic             hazard_stall;
    logic [CNT_W-1:0] bubble_cnt;
    logic [1:0]       dbg_state;

    modport master (
        output id_valid, id_regdst, id_memtoreg, id_alusrc, id_regwrite,
               id_jump, id_branch, id_memread, id_memwrite, id_aluop,
               id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
               flush, stall_in,
        input  ex_valid, ex_regdst, ex_memtoreg, ex_alusrc, ex_regwrite,
               ex_jump, ex_branch, ex_memread, ex_memwrite, ex_aluop,
               ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
               hazard_stall, bubble_cnt, dbg_state
    );

    modport slave (
        input  id_valid, id_regdst, id_memtoreg, id_alusrc, id_regwrite,
               id_jump, id_branch, id_memread, id_memwrite, id_aluop,
               id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
               flush, stall_in,
        output ex_valid, ex_regdst, ex_memtoreg, ex_alusrc, ex_regwrite,
               ex_jump, ex_branch, ex_memread, ex_memwrite, ex_aluop,
               ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
               hazard_stall, bubble_cnt, dbg_state
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and downstream hold.
// HAZARD_DETECT_EN enables load-use detection and the bubble counter; otherwise both are tied to 0.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input logic   clk,
    input logic   rst_n,
    id_ex_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HELD  = 2'd2
    } state_e;

    typedef struct packed {
        logic        valid;
        logic        regdst;
        logic        memtoreg;
        logic        alusrc;
        logic        regwrite;
        logic [1:0]  jump;
        logic [1:0]  branch;
        logic [1:0]  memread;
        logic [1:0]  memwrite;
        logic [1:0]  aluop;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
    } ex_t;

    ex_t    ex_q, ex_d, cap;
    logic   hazard;
    state_e state;

    function automatic ex_t make_bubble(input ex_t e);
        ex_t b;
        b          = e;
        b.valid    = 1'b0;
        b.regdst   = 1'b0;
        b.memtoreg = 1'b0;
        b.alusrc   = 1'b0;
        b.regwrite = 1'b0;
        b.jump     = 2'b00;
        b.branch   = 2'b00;
        b.memread  = 2'b00;
        b.memwrite = 2'b00;
        b.aluop    = 2'b00;
        return b;
    endfunction

`ifdef HAZARD_DETECT_EN
    logic             uses_rt;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Logical && short-circuits on id_valid = 0, so X decode fields cannot leak into the stall.
    assign uses_rt = (bus.id_memwrite != 2'b00) || ((bus.id_jump == 2'b00) && !bus.id_alusrc);
    assign hazard  = bus.id_valid && ex_q.valid && (ex_q.memread != 2'b00) && ex_q.regwrite &&
                     (ex_q.rt != 5'd0) &&
                     ((ex_q.rt == bus.id_rs) || (uses_rt && (ex_q.rt == bus.id_rt)));

    always_comb begin
        cnt_d = cnt_q;
        if (!bus.flush && !bus.stall_in && hazard && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bus.bubble_cnt = cnt_q;
`else
    assign hazard         = 1'b0;
    assign bus.bubble_cnt = '0;
`endif

    always_comb begin
        cap.valid    = bus.id_valid;
        cap.regdst   = bus.id_regdst;
        cap.memtoreg = bus.id_memtoreg;
        cap.alusrc   = bus.id_alusrc;
        cap.regwrite = bus.id_regwrite;
        cap.jump     = bus.id_jump;
        cap.branch   = bus.id_branch;
        cap.memread  = bus.id_memread;
        cap.memwrite = bus.id_memwrite;
        cap.aluop    = bus.id_aluop;
        cap.pc4      = bus.id_pc4;
        cap.rd1      = bus.id_rd1;
        cap.rd2      = bus.id_rd2;
        cap.imm      = bus.id_imm;
        cap.rs       = bus.id_rs;
        cap.rt       = bus.id_rt;
        cap.rd       = bus.id_rd;
        cap.funct    = bus.id_funct;
        if (!bus.id_valid) cap = make_bubble(cap);
    end

    always_comb begin
        ex_d = ex_q;
        if (bus.flush)         ex_d = make_bubble(ex_q);
        else if (bus.stall_in) ex_d = ex_q;
        else if (hazard)       ex_d = make_bubble(ex_q);
        else                   ex_d = cap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    always_comb begin
        if (bus.stall_in)    state = ST_HELD;
        else if (ex_q.valid) state = ST_FULL;
        else                 state = ST_EMPTY;
    end

    assign bus.dbg_state    = state;
    assign bus.hazard_stall = hazard;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_regdst    = ex_q.regdst;
    assign bus.ex_memtoreg  = ex_q.memtoreg;
    assign bus.ex_alusrc    = ex_q.alusrc;
    assign bus.ex_regwrite  = ex_q.regwrite;
    assign bus.ex_jump      = ex_q.jump;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_memread   = ex_q.memread;
    assign bus.ex_memwrite  = ex_q.memwrite;
    assign bus.ex_aluop     = ex_q.aluop;
    assign bus.ex_pc4       = ex_q.pc4;
    assign bus.ex_rd1       = ex_q.rd1;
    assign bus.ex_rd2       = ex_q.rd2;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rs        = ex_q.rs;
    assign bus.ex_rt        = ex_q.rt;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_funct     = ex_q.funct;

endmodule
